// File: rtl/alu_seq.sv
// alu_seq - registered, handshaked ALU with a 4-bit opcode space and {N,Z,C,V} flags.
//
// Single-cycle opcodes complete on the accepting edge, so a new operation can be
// accepted on every clock. The shifts (LSL/LSR/ASR) move one bit per clock.
// MUL is an iterative shift-add that takes WIDTH clocks.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   : opcode 8 is the iterative WIDTH-cycle multiply (MUL state built)
//   undefined : opcode 8 is a single-cycle pass of OP0 with JMP-style flags
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   in_valid   operation request
//   in_ready   high when an operation can be accepted (IDLE)
//   func       opcode
//   OP0, OP1   operands (OP1 also gives the shift amount)
//   flag_en    1 = flags from result, 0 = pass flag_in through
//   flag_in    current flags {N,Z,C,V}
//   out_valid  one-cycle pulse when Q/flag_out update
//   Q          registered result
//   flag_out   registered flags {N,Z,C,V}
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] OP0,
  input  logic [WIDTH-1:0] OP1,
  input  logic             flag_en,
  input  logic [3:0]       flag_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] Q,
  output logic [3:0]       flag_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);

  localparam logic [3:0] OP_JMP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_LSL = 4'h3,
                         OP_LSR = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
                         OP_MUL = 4'h8, OP_ASR = 4'h9, OP_MOV = 4'hA, OP_BEQ = 4'hB,
                         OP_BNE = 4'hC, OP_BLT = 4'hD, OP_BGT = 4'hE, OP_CMP = 4'hF;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [3:0]       flag_reg, flag_next;
  logic             out_valid_reg, out_valid_next;
  logic [3:0]       func_reg, func_next;
  logic [WIDTH-1:0] work_reg, work_next;   // shift value, or multiplicand for MUL
  logic [CW-1:0]    cnt_reg, cnt_next;     // iterations still to run
  logic             fen_reg, fen_next;
  logic [3:0]       fin_reg, fin_next;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mplr_reg, mplr_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] acc_sum;
`endif

  function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] r, input logic c, input logic v);
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  // Single-cycle datapath working straight from the input ports (used on acceptance).
  logic [WIDTH:0]   sum, diff;
  logic             add_v, sub_v, cond;
  logic [WIDTH-1:0] sc_q;
  logic             sc_c, sc_v, sc_hold_q, sc_branch, sc_shift;
  logic [3:0]       sc_flags;
  logic [CW-1:0]    n_amt;

  always_comb begin
    sum   = {1'b0, OP0} + {1'b0, OP1};
    diff  = {1'b0, OP0} - {1'b0, OP1};
    add_v = (OP0[WIDTH-1] == OP1[WIDTH-1]) && (sum[WIDTH-1] != OP0[WIDTH-1]);
    sub_v = (OP0[WIDTH-1] != OP1[WIDTH-1]) && (diff[WIDTH-1] != OP0[WIDTH-1]);
    n_amt = (OP1 >= W_VAL) ? CNT_MAX : OP1[CW-1:0];
    sc_q      = OP0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    sc_hold_q = 1'b0;
    sc_branch = 1'b0;
    sc_shift  = 1'b0;
    cond      = 1'b0;
    case (func)
      OP_ADD: begin sc_q = sum[WIDTH-1:0]; sc_c = sum[WIDTH]; sc_v = add_v; end
      OP_SUB, OP_CMP: begin
        sc_q      = diff[WIDTH-1:0];
        sc_c      = ~diff[WIDTH];            // no-borrow
        sc_v      = sub_v;
        sc_hold_q = (func == OP_CMP);        // CMP only updates flags
      end
      OP_LSL, OP_LSR, OP_ASR: sc_shift = 1'b1;  // n=0 result is OP0, C=0
      OP_AND: sc_q = OP0 & OP1;
      OP_OR:  sc_q = OP0 | OP1;
      OP_XOR: sc_q = OP0 ^ OP1;
      OP_MOV: sc_q = OP1;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGT: begin
        sc_branch = 1'b1;
        case (func)
          OP_BEQ:  cond = flag_in[2];
          OP_BNE:  cond = ~flag_in[2];
          OP_BLT:  cond = flag_in[3] ^ flag_in[0];
          default: cond = ~flag_in[2] && !(flag_in[3] ^ flag_in[0]);
        endcase
        sc_q = cond ? OP0 : OP1;
      end
      default: sc_q = OP0;                   // JMP, and MUL when not built
    endcase
    sc_flags = (sc_branch || !flag_en) ? flag_in : nzcv(sc_q, sc_c, sc_v);
  end

  // One shift step on the working value.
  logic [WIDTH-1:0] sh_q;
  logic             sh_c;

  always_comb begin
    sh_q = work_reg;
    sh_c = 1'b0;
    case (func_reg)
      OP_LSL:  begin sh_q = {work_reg[WIDTH-2:0], 1'b0};           sh_c = work_reg[WIDTH-1]; end
      OP_LSR:  begin sh_q = {1'b0, work_reg[WIDTH-1:1]};           sh_c = work_reg[0];       end
      default: begin sh_q = {work_reg[WIDTH-1], work_reg[WIDTH-1:1]}; sh_c = work_reg[0];    end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  assign acc_sum = acc_reg + (mplr_reg[0] ? work_reg : '0);
`endif

  always_comb begin
    state_next     = state_reg;
    q_next         = q_reg;
    flag_next      = flag_reg;
    out_valid_next = 1'b0;
    func_next      = func_reg;
    work_next      = work_reg;
    cnt_next       = cnt_reg;
    fen_next       = fen_reg;
    fin_next       = fin_reg;
`ifdef ALU_SEQ_MUL_EN
    mplr_next      = mplr_reg;
    acc_next       = acc_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          func_next = func;
          fen_next  = flag_en;
          fin_next  = flag_in;
          if (sc_shift && (n_amt != '0)) begin
            work_next  = OP0;
            cnt_next   = n_amt;
            state_next = SHIFT;
`ifdef ALU_SEQ_MUL_EN
          end else if (func == OP_MUL) begin
            work_next  = OP0;
            mplr_next  = OP1;
            acc_next   = '0;
            cnt_next   = CNT_MAX;
            state_next = MUL;
`endif
          end else begin
            if (!sc_hold_q) q_next = sc_q;
            flag_next      = sc_flags;
            out_valid_next = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_next = sh_q;
        cnt_next  = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          q_next         = sh_q;
          flag_next      = fen_reg ? nzcv(sh_q, sh_c, 1'b0) : fin_reg;
          out_valid_next = 1'b1;
          state_next     = IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      MUL: begin
        acc_next  = acc_sum;
        work_next = {work_reg[WIDTH-2:0], 1'b0};
        mplr_next = {1'b0, mplr_reg[WIDTH-1:1]};
        cnt_next  = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          q_next         = acc_sum;
          flag_next      = fen_reg ? nzcv(acc_sum, 1'b0, 1'b0) : fin_reg;
          out_valid_next = 1'b1;
          state_next     = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      q_reg         <= '0;
      flag_reg      <= '0;
      out_valid_reg <= 1'b0;
      func_reg      <= '0;
      work_reg      <= '0;
      cnt_reg       <= '0;
      fen_reg       <= 1'b0;
      fin_reg       <= '0;
`ifdef ALU_SEQ_MUL_EN
      mplr_reg      <= '0;
      acc_reg       <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      q_reg         <= q_next;
      flag_reg      <= flag_next;
      out_valid_reg <= out_valid_next;
      func_reg      <= func_next;
      work_reg      <= work_next;
      cnt_reg       <= cnt_next;
      fen_reg       <= fen_next;
      fin_reg       <= fin_next;
`ifdef ALU_SEQ_MUL_EN
      mplr_reg      <= mplr_next;
      acc_reg       <= acc_next;
`endif
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign Q         = q_reg;
  assign flag_out  = flag_reg;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq - directed-vector bench for alu_seq (WIDTH=16), hand-computed expectations.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  func;
  logic [15:0] OP0, OP1;
  logic        flag_en;
  logic [3:0]  flag_in;
  logic        out_valid;
  logic [15:0] Q;
  logic [3:0]  flag_out;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .OP0(OP0), .OP1(OP1), .flag_en(flag_en), .flag_in(flag_in),
    .out_valid(out_valid), .Q(Q), .flag_out(flag_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op (called just after a rising edge), keep in_valid high with junk
  // inputs while the op is busy, then check latency, result, flags and the pulse.
  task automatic do_op(input string tag, input logic [3:0] f, input logic [15:0] a,
                       input logic [15:0] b, input logic fe, input logic [3:0] fi,
                       input int exp_lat, input logic [15:0] exp_q, input logic [3:0] exp_fl);
    int k;
    chk({tag, ".ready"}, in_ready, 1);
    func = f; OP0 = a; OP1 = b; flag_en = fe; flag_in = fi; in_valid = 1'b1;
    @(posedge clk); #1;
    func = ~f; OP0 = ~a; OP1 = ~b; flag_en = ~fe; flag_in = ~fi;
    if (exp_lat > 0) chk({tag, ".busy"}, in_ready, 0);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    chk({tag, ".lat"}, k, exp_lat);
    chk({tag, ".q"}, Q, exp_q);
    chk({tag, ".flags"}, flag_out, exp_fl);
    $display("op %s func=%h a=%h b=%h -> Q=%h flags=%b lat=%0d", tag, f, a, b, Q, flag_out, k);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, out_valid, 0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; in_valid = 1'b0; func = 4'h0; OP0 = '0; OP1 = '0;
    flag_en = 1'b0; flag_in = 4'h0;
    #1;
    chk("rst.q", Q, 0);
    chk("rst.flags", flag_out, 0);
    chk("rst.ov", out_valid, 0);
    chk("rst.ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_op("add",  4'h1, 16'h8001, 16'h8001, 1'b1, 4'b0000, 0, 16'h0002, 4'b0011);
    do_op("sub",  4'h2, 16'h0005, 16'h000A, 1'b1, 4'b0000, 0, 16'hFFFB, 4'b1000);
    do_op("mov",  4'hA, 16'h0000, 16'h1234, 1'b0, 4'b0101, 0, 16'h1234, 4'b0101);
    do_op("cmp",  4'hF, 16'h0005, 16'h000A, 1'b1, 4'b0000, 0, 16'h1234, 4'b1000);
    do_op("lsl4", 4'h3, 16'h0001, 16'h0004, 1'b1, 4'b1111, 4, 16'h0010, 4'b0000);
    do_op("lsl32",4'h3, 16'h0001, 16'h0020, 1'b1, 4'b0000, 16, 16'h0000, 4'b0110);
    do_op("lsr16",4'h4, 16'h8000, 16'h0010, 1'b1, 4'b0000, 16, 16'h0000, 4'b0110);
    do_op("asr2", 4'h9, 16'h8006, 16'h0002, 1'b1, 4'b0000, 2, 16'hE001, 4'b1010);
    do_op("lsr0", 4'h4, 16'h8000, 16'h0000, 1'b1, 4'b0011, 0, 16'h8000, 4'b1000);
`ifdef ALU_SEQ_MUL_EN
    do_op("mul",  4'h8, 16'h0003, 16'h0005, 1'b1, 4'b1111, 16, 16'h000F, 4'b0000);
`else
    do_op("mul",  4'h8, 16'h0003, 16'h0005, 1'b1, 4'b1111, 0, 16'h0003, 4'b0000);
`endif
    do_op("and",  4'h5, 16'hF0F0, 16'h0FF0, 1'b1, 4'b1111, 0, 16'h00F0, 4'b0000);
    do_op("xor",  4'h7, 16'hAAAA, 16'hAAAA, 1'b1, 4'b0000, 0, 16'h0000, 4'b0100);
    do_op("addnf",4'h1, 16'h0003, 16'h0004, 1'b0, 4'b1011, 0, 16'h0007, 4'b1011);
    do_op("blt",  4'hD, 16'h0040, 16'h0002, 1'b1, 4'b1000, 0, 16'h0040, 4'b1000);
    do_op("bgt",  4'hE, 16'h0040, 16'h0002, 1'b1, 4'b1000, 0, 16'h0002, 4'b1000);
    do_op("beq",  4'hB, 16'h0007, 16'h0009, 1'b1, 4'b0100, 0, 16'h0007, 4'b0100);

    // Back-to-back single-cycle ops, one accepted every clock.
    func = 4'h1; OP0 = 16'h0001; OP1 = 16'h0002; flag_en = 1'b1; flag_in = 4'h0; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b1.ov", out_valid, 1);
    chk("b2b1.q", Q, 16'h0003);
    func = 4'h2; OP0 = 16'h0009; OP1 = 16'h0004;
    @(posedge clk); #1;
    chk("b2b2.ov", out_valid, 1);
    chk("b2b2.q", Q, 16'h0005);
    chk("b2b2.flags", flag_out, 4'b0010);
    in_valid = 1'b0;
    $display("op b2b add/sub -> Q=%h flags=%b", Q, flag_out);
    @(posedge clk); #1;
    chk("b2b.pulse", out_valid, 0);

    // Reset partway through a long multi-cycle op.
`ifdef ALU_SEQ_MUL_EN
    func = 4'h8; OP0 = 16'h0003; OP1 = 16'h0005;
`else
    func = 4'h3; OP0 = 16'h0001; OP1 = 16'h0010;
`endif
    flag_en = 1'b1; flag_in = 4'h0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort.q", Q, 0);
    chk("abort.flags", flag_out, 0);
    chk("abort.ov", out_valid, 0);
    chk("abort.ready", in_ready, 1);
    @(posedge clk); #1 rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("abort.nopulse", pulses, 0);
    $display("op abort -> Q=%h flags=%b pulses=%0d", Q, flag_out, pulses);
    do_op("addpost", 4'h1, 16'h0001, 16'h0001, 1'b1, 4'b0000, 0, 16'h0002, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
